rc5_decrypt: RTL and testbench
==============================

Name: rc5_decrypt

Overview:
- Iterative RC5-16 block decryptor that consumes the expanded subkey table and ready flag from the key-expansion block.
- Converts one 32-bit ciphertext block to plaintext, one half-round per clock cycle.
- Sits beside the key expander in the accelerator datapath and uses the same start/ready-style handshake.

Parameters:
- W_SIZE, 16, word size in bits; rotation amount uses the low log2(W_SIZE)=4 bits.
- T_MAX, 34, subkey table depth (2*(16+1)).
- MAX_ROUNDS, 16, largest supported round count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request to decrypt; level-sensitive.
- key_ready  in  1  subkey table valid (key-expansion ready); start is ignored while low.
- num_rounds  in  5  round count r; latched on accept.
- subkeys  in  T_MAX x W_SIZE  S[0..33]; must stay stable while busy.
- ciphertext  in  32  {B,A}: B=[31:16], A=[15:0]; latched on accept.
- plaintext  out  32  {B,A} result; registered.
- busy  out  1  high from accept until DONE is entered.
- done  out  1  result valid.

Behaviour:
- Reset (rst low, any time, including mid-operation):
  - state=IDLE.
  - A, B, round counter and plaintext cleared to 0.
  - busy=0, done=0.
  - Takes effect immediately, with no clock required.
- States: IDLE, ROUND_B, ROUND_A, FINAL, DONE.
- IDLE:
  - Accept when start=1 and key_ready=1.
  - On accept, latch A=ciphertext[15:0], B=ciphertext[31:16], and rnd=min(num_rounds,16).
  - Next state is ROUND_B if rnd>0, otherwise FINAL.
  - If start=1 but key_ready=0, remain in IDLE.
- ROUND_B: B <= ROTR(B - S[2*rnd+1], A[3:0]) ^ A; next state ROUND_A.
- ROUND_A:
  - A <= ROTR(A - S[2*rnd], B[3:0]) ^ B, where B is the value updated in ROUND_B.
  - rnd <= rnd-1.
  - Next state is FINAL if rnd==1, otherwise ROUND_B.
- FINAL: B <= B - S[1]; A <= A - S[0]; plaintext <= {B-S[1], A-S[0]}; next state DONE.
- DONE:
  - done=1.
  - Stay in DONE while start=1; go to IDLE when start=0 (same release rule as the key expander).
  - plaintext holds its value until the next FINAL or reset.
- Arithmetic:
  - All add/sub is modulo 2^16.
  - Rotate-right by 0 is identity.
  - Subkey index is 6 bits; with rnd≤16 the maximum index is 33.
- Latency: accept edge, then 2r half-round edges, then 1 FINAL edge. done is high in the cycle after edge number 2r+1 following accept.
- busy and done are decoded combinationally from state:
  - busy = state in {ROUND_B, ROUND_A, FINAL}.
  - done = state==DONE.
- start asserted while busy is ignored. Changes to ciphertext or num_rounds after accept have no effect.
- num_rounds values 17..31 saturate to 16.

Decomposition:
- Shared package rc5_pkg holds:
  - W_SIZE, T_MAX, MAX_ROUNDS, and the P/Q magic constants (shared with the key expander).
  - The state enum type.
  - A word typedef (logic [W_SIZE-1:0]).
- One sub-module, rotr: combinational rotate-right mirroring the existing rotate-left block, with the same port style (data_i, n_i, data_o).
- Instantiate rotr twice: one instance for the B update, one for the A update.

Test Plan:
- r=0, S[0]=16'h0001, S[1]=16'h0002, ciphertext=32'h0003_0005 -> plaintext=32'h0001_0004; done rises in the cycle after the 1st edge following accept.
- r=1, all subkeys 0, ciphertext=32'h0000_0001 -> plaintext=32'h0001_8001; done rises after 3 edges following accept.
- r=12 and r=16 with real subkeys from the key expander (key=128'h0), 100 random blocks each -> plaintext equals the reference model's decryption; round-tripping through the software encryptor recovers the original block.
- num_rounds=5'd20 -> result identical to the num_rounds=16 run; busy lasts 33 cycles.
- start=1 with key_ready=0 for 5 cycles -> stays IDLE, busy=0. Raising key_ready then starts decryption. Holding start in DONE keeps done=1; dropping start returns to IDLE next edge.
- rst driven low mid-ROUND_A (between clock edges) -> plaintext=0, busy=0, done=0 immediately. After release, a fresh start produces the correct result.

Source files
------------

// File: rtl/rc5_pkg.sv
// Shared RC5-16 definitions for the key expander and the block decryptor.
// Word size, table depth, magic constants and the decryptor state type.
package rc5_pkg;

    localparam int W_SIZE     = 16;
    localparam int T_MAX      = 34;
    localparam int MAX_ROUNDS = 16;

    // RC5 magic constants for w=16, derived from e and the golden ratio
    localparam logic [W_SIZE-1:0] P_CONST = 16'hB7E1;
    localparam logic [W_SIZE-1:0] Q_CONST = 16'h9E37;

    typedef logic [W_SIZE-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        ROUND_B,
        ROUND_A,
        FINAL,
        DONE
    } state_t;

endpackage

// File: rtl/rc5_decrypt_rotr.sv
// Combinational rotate-right by a data-dependent amount.
// Mirrors the rotate-left block used by the key expander.
module rotr #(
    parameter int W = 16
) (
    input  logic [W-1:0]         data_i,
    input  logic [$clog2(W)-1:0] n_i,
    output logic [W-1:0]         data_o
);

    // A shift by W yields zero, so a rotate of 0 collapses to the identity
    assign data_o = (data_i >> n_i) | (data_i << (W - int'(n_i)));

endmodule

// File: rtl/rc5_decrypt.sv
// Iterative RC5-16 block decryptor, one half-round per clock.
// Consumes the expanded subkey table produced by the key expander.
import rc5_pkg::*;

module rc5_decrypt (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        key_ready,
    input  logic [4:0]  num_rounds,
    input  word_t       subkeys [T_MAX],
    input  logic [31:0] ciphertext,
    output logic [31:0] plaintext,
    output logic        busy,
    output logic        done
);

    state_t      r_state;
    word_t       r_a;
    word_t       r_b;
    logic [4:0]  r_rnd;
    logic [31:0] r_plaintext;

    logic [5:0]  w_idx_b;
    logic [5:0]  w_idx_a;
    word_t       w_diff_b;
    word_t       w_diff_a;
    word_t       w_rot_b;
    word_t       w_rot_a;
    word_t       w_new_b;
    word_t       w_new_a;
    word_t       w_fin_b;
    word_t       w_fin_a;
    logic [4:0]  w_rnd_sat;

    assign w_idx_b   = {r_rnd, 1'b1};
    assign w_idx_a   = {r_rnd, 1'b0};
    assign w_diff_b  = r_b - subkeys[w_idx_b];
    assign w_diff_a  = r_a - subkeys[w_idx_a];
    assign w_new_b   = w_rot_b ^ r_a;
    // In ROUND_A, r_b already holds the value written during ROUND_B
    assign w_new_a   = w_rot_a ^ r_b;
    assign w_fin_b   = r_b - subkeys[1];
    assign w_fin_a   = r_a - subkeys[0];
    assign w_rnd_sat = (num_rounds > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : num_rounds;

    rotr #(.W(W_SIZE)) u_rotr_b (
        .data_i (w_diff_b),
        .n_i    (r_a[3:0]),
        .data_o (w_rot_b)
    );

    rotr #(.W(W_SIZE)) u_rotr_a (
        .data_i (w_diff_a),
        .n_i    (r_b[3:0]),
        .data_o (w_rot_a)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_rnd       <= '0;
            r_plaintext <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && key_ready) begin
                        r_a     <= ciphertext[15:0];
                        r_b     <= ciphertext[31:16];
                        r_rnd   <= w_rnd_sat;
                        r_state <= (w_rnd_sat != 5'd0) ? ROUND_B : FINAL;
                    end
                end
                ROUND_B: begin
                    r_b     <= w_new_b;
                    r_state <= ROUND_A;
                end
                ROUND_A: begin
                    r_a     <= w_new_a;
                    r_rnd   <= r_rnd - 5'd1;
                    r_state <= (r_rnd == 5'd1) ? FINAL : ROUND_B;
                end
                FINAL: begin
                    r_b         <= w_fin_b;
                    r_a         <= w_fin_a;
                    r_plaintext <= {w_fin_b, w_fin_a};
                    r_state     <= DONE;
                end
                DONE: begin
                    // Hold the result until the requester drops start
                    if (!start) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign plaintext = r_plaintext;
    assign busy      = (r_state == ROUND_B) || (r_state == ROUND_A) || (r_state == FINAL);
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_rc5_decrypt.sv
// Directed bench for rc5_decrypt: hand-computed vectors plus a round trip
// through a software RC5-16 encryptor keyed by a zero-key expansion.
import rc5_pkg::*;

module tb_rc5_decrypt;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        keyReady;
    logic [4:0]  numRounds;
    word_t       subkeys [T_MAX];
    logic [31:0] ciphertext;
    logic [31:0] plaintext;
    logic        busy;
    logic        done;

    int checkCount = 0;
    int passCount  = 0;

    rc5_decrypt dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_ready  (keyReady),
        .num_rounds (numRounds),
        .subkeys    (subkeys),
        .ciphertext (ciphertext),
        .plaintext  (plaintext),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic word_t rotl16(input word_t x, input int n);
        int m;
        m = n & 15;
        return (x << m) | (x >> (16 - m));
    endfunction

    // Standard RC5 schedule for a 16-byte all-zero key over the full table
    task automatic expandZeroKey();
        word_t l [8];
        word_t a;
        word_t b;
        int    i;
        int    j;
        for (int k = 0; k < 8; k++) l[k] = '0;
        subkeys[0] = P_CONST;
        for (int k = 1; k < T_MAX; k++) subkeys[k] = subkeys[k-1] + Q_CONST;
        a = '0; b = '0; i = 0; j = 0;
        for (int k = 0; k < 3 * T_MAX; k++) begin
            subkeys[i] = rotl16(subkeys[i] + a + b, 3);
            a = subkeys[i];
            l[j] = rotl16(l[j] + a + b, int'(a) + int'(b));
            b = l[j];
            i = (i + 1) % T_MAX;
            j = (j + 1) % 8;
        end
    endtask

    function automatic logic [31:0] encryptBlock(input logic [31:0] pt, input int r);
        word_t a;
        word_t b;
        a = pt[15:0] + subkeys[0];
        b = pt[31:16] + subkeys[1];
        for (int i = 1; i <= r; i++) begin
            a = rotl16(a ^ b, int'(b)) + subkeys[2*i];
            b = rotl16(b ^ a, int'(a)) + subkeys[2*i+1];
        end
        return {b, a};
    endfunction

    // Issue one block, scramble the inputs after accept, wait for done
    task automatic applyStimulus(input logic [4:0] rounds, input logic [31:0] ct,
                                 output logic [31:0] pt, output int edges, output int busyCycles);
        @(negedge clk);
        ciphertext = ct;
        numRounds  = rounds;
        start      = 1'b1;
        @(posedge clk);
        #1;
        ciphertext = ~ct;
        numRounds  = 5'd0;
        busyCycles = busy ? 1 : 0;
        edges      = 0;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busyCycles++;
        end
        pt = plaintext;
    endtask

    task automatic releaseStart();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idleAfterRelease", {30'd0, busy, done}, 32'd0);
    endtask

    logic [31:0] pt;
    logic [31:0] ptRef;
    logic [31:0] ct;
    int          edges;
    int          busyCycles;

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        keyReady  = 1'b1;
        numRounds = 5'd0;
        ciphertext = '0;
        for (int k = 0; k < T_MAX; k++) subkeys[k] = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetPlaintext", plaintext, 32'd0);
        checkOutput("resetBusyDone", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // r=0: only the final subtraction applies
        subkeys[0] = 16'h0001;
        subkeys[1] = 16'h0002;
        applyStimulus(5'd0, 32'h0003_0005, pt, edges, busyCycles);
        checkOutput("r0Plaintext", pt, 32'h0001_0004);
        checkOutput("r0Latency", edges, 32'd1);
        releaseStart();

        // r=1 with zero subkeys: A rotates 1 right by 1 to 8000, then ^B
        subkeys[0] = '0;
        subkeys[1] = '0;
        applyStimulus(5'd1, 32'h0000_0001, pt, edges, busyCycles);
        checkOutput("r1Plaintext", pt, 32'h0001_8001);
        checkOutput("r1Latency", edges, 32'd3);
        releaseStart();

        expandZeroKey();

        // start is ignored until key_ready rises
        keyReady = 1'b0;
        ptRef = 32'h1234_5678;
        @(negedge clk);
        ciphertext = encryptBlock(ptRef, 8);
        numRounds  = 5'd8;
        start      = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("noKeyReadyIdle", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        keyReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("keyReadyAccept", {31'd0, busy}, 32'd1);
        edges = 0;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput("keyReadyPlaintext", plaintext, ptRef);
        checkOutput("keyReadyLatency", edges, 32'd17);
        @(posedge clk);
        #1;
        checkOutput("doneHeld", {31'd0, done}, 32'd1);
        releaseStart();

        for (int n = 0; n < 100; n++) begin
            ptRef = $urandom;
            ct = encryptBlock(ptRef, 12);
            applyStimulus(5'd12, ct, pt, edges, busyCycles);
            checkOutput("r12RoundTrip", pt, ptRef);
            if (n == 0) checkOutput("r12Latency", edges, 32'd25);
            releaseStart();
        end

        for (int n = 0; n < 100; n++) begin
            ptRef = $urandom;
            ct = encryptBlock(ptRef, 16);
            applyStimulus(5'd16, ct, pt, edges, busyCycles);
            checkOutput("r16RoundTrip", pt, ptRef);
            if (n == 0) checkOutput("r16Latency", edges, 32'd33);
            releaseStart();
        end

        // num_rounds above 16 saturates
        ptRef = 32'hCAFE_F00D;
        ct = encryptBlock(ptRef, 16);
        applyStimulus(5'd20, ct, pt, edges, busyCycles);
        checkOutput("r20Saturated", pt, ptRef);
        checkOutput("r20BusyCycles", busyCycles, 32'd33);
        releaseStart();

        // Asynchronous reset while in ROUND_A, then a clean rerun
        @(negedge clk);
        ciphertext = ct;
        numRounds  = 5'd16;
        start      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midResetPlaintext", plaintext, 32'd0);
        checkOutput("midResetBusyDone", {30'd0, busy, done}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ptRef = 32'h0BAD_BEEF;
        ct = encryptBlock(ptRef, 16);
        applyStimulus(5'd16, ct, pt, edges, busyCycles);
        checkOutput("afterResetPlaintext", pt, ptRef);
        releaseStart();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
